// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - link-side/channel-side signal bundle for tdm_demux
interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      fsync;
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]       ch_upd;
  logic                      frame_valid;
  logic                      locked;
  logic                      sync_err;

  modport master (
    output din, din_valid, fsync,
    input  ch_data, ch_upd, frame_valid, locked, sync_err
  );

  modport slave (
    input  din, din_valid, fsync,
    output ch_data, ch_upd, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM slot demultiplexer with HUNT/LOCK framing; TDM_DEMUX_SHADOW_EN selects atomic frame update
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);
  localparam int CW = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [CHANNELS*WIDTH-1:0] r_data;
  logic [CHANNELS-1:0]       r_upd;
  logic                      r_fv;
  logic                      r_err;
`ifdef TDM_DEMUX_SHADOW_EN
  logic [WIDTH-1:0]          r_shadow [CHANNELS];
`endif

  logic          w_cap;
  logic          w_err;
  logic          w_done;
  logic [CW-1:0] w_slot;

  // An fsync beat is always written to slot 0, whether it opens or restarts a frame.
  always_comb begin
    w_cap  = 1'b0;
    w_err  = 1'b0;
    w_done = 1'b0;
    w_slot = bus.fsync ? '0 : r_cnt;
    if (bus.din_valid) begin
      if (r_state == HUNT) begin
        w_cap = bus.fsync;
      end else if (r_cnt == '0) begin
        w_cap = bus.fsync;
        w_err = !bus.fsync;
      end else begin
        w_cap  = 1'b1;
        w_err  = bus.fsync;
        w_done = !bus.fsync && (r_cnt == LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_cnt   <= '0;
      r_data  <= '0;
      r_upd   <= '0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
`ifdef TDM_DEMUX_SHADOW_EN
      for (int c = 0; c < CHANNELS; c++) r_shadow[c] <= '0;
`endif
    end else begin
      r_upd <= '0;
      r_fv  <= w_done;
      r_err <= w_err;

      if (bus.din_valid) begin
        case (r_state)
          HUNT: if (bus.fsync) r_state <= LOCK;
          LOCK: if (r_cnt == '0 && !bus.fsync) r_state <= HUNT;
          default: r_state <= HUNT;
        endcase
      end

      if (w_cap) begin
        if (bus.fsync)          r_cnt <= ONE;
        else if (r_cnt == LAST) r_cnt <= '0;
        else                    r_cnt <= r_cnt + ONE;
      end

`ifdef TDM_DEMUX_SHADOW_EN
      if (w_cap) r_shadow[w_slot] <= bus.din;
      // The last slot bypasses the shadow so the whole frame lands on one edge.
      if (w_done) begin
        for (int c = 0; c < CHANNELS; c++) begin
          r_data[c*WIDTH +: WIDTH] <= (c == CHANNELS - 1) ? bus.din : r_shadow[c];
        end
        r_upd <= '1;
      end
`else
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_cap && w_slot == CW'(c)) begin
          r_data[c*WIDTH +: WIDTH] <= bus.din;
          r_upd[c]                 <= 1'b1;
        end
      end
`endif
    end
  end

  assign bus.ch_data     = r_data;
  assign bus.ch_upd      = r_upd;
  assign bus.frame_valid = r_fv;
  assign bus.sync_err    = r_err;
  assign bus.locked      = (r_state == LOCK);
endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed and randomized bench for tdm_demux against a frame-level model
module tb_tdm_demux;
  localparam int CH = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: lock flag, beats of the frame in progress, visible channel values.
  bit         m_lock;
  logic [7:0] m_frame [$];
  logic [7:0] m_ch [CH];
  logic [3:0] m_upd;
  logic       m_fv;
  logic       m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_packed();
    logic [31:0] v;
    for (int c = 0; c < CH; c++) v[c*W +: W] = m_ch[c];
    return v;
  endfunction

  task automatic m_reset();
    m_lock = 0;
    m_frame.delete();
    for (int c = 0; c < CH; c++) m_ch[c] = '0;
    m_upd = '0; m_fv = 0; m_err = 0;
  endtask

  task automatic m_put(input logic [7:0] d);
    int slot;
    slot = m_frame.size();
    m_frame.push_back(d);
`ifndef TDM_DEMUX_SHADOW_EN
    m_ch[slot] = d;
    m_upd[slot] = 1'b1;
`endif
    if (m_frame.size() == CH) begin
      m_fv = 1;
`ifdef TDM_DEMUX_SHADOW_EN
      for (int c = 0; c < CH; c++) m_ch[c] = m_frame[c];
      m_upd = 4'hF;
`endif
      m_frame.delete();
    end
  endtask

  task automatic m_step(input logic v, input logic f, input logic [7:0] d);
    m_upd = '0; m_fv = 0; m_err = 0;
    if (v) begin
      if (!m_lock) begin
        if (f) begin
          m_lock = 1;
          m_frame.delete();
          m_put(d);
        end
      end else if (m_frame.size() == 0 && !f) begin
        m_err = 1;
        m_lock = 0;
      end else begin
        if (f) begin
          if (m_frame.size() != 0) m_err = 1;
          m_frame.delete();
        end
        m_put(d);
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ch_data"}, bus.ch_data, m_packed());
    chk({tag, ".ch_upd"}, bus.ch_upd, m_upd);
    chk({tag, ".frame_valid"}, bus.frame_valid, m_fv);
    chk({tag, ".locked"}, bus.locked, m_lock);
    chk({tag, ".sync_err"}, bus.sync_err, m_err);
  endtask

  task automatic beat(input string tag, input logic v, input logic f, input logic [7:0] d);
    @(negedge clk);
    bus.din = d; bus.din_valid = v; bus.fsync = f;
    @(posedge clk);
    #1;
    m_step(v, f, d);
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    beat(tag, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  initial begin
    bus.din = '0; bus.din_valid = 0; bus.fsync = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    beat("hunt_aa", 1, 0, 8'hAA);
    beat("hunt_bb", 1, 0, 8'hBB);
    chk("hunt_data_zero", bus.ch_data, 32'h0);
    chk("hunt_unlocked", bus.locked, 1'b0);

    beat("f1_s0", 1, 1, 8'h11);
    chk("f1_locked", bus.locked, 1'b1);
    beat("f1_s1", 1, 0, 8'h22);
    beat("f1_s2", 1, 0, 8'h33);
    beat("f1_s3", 1, 0, 8'h44);
    chk("f1_data", bus.ch_data, 32'h44332211);
    chk("f1_fv", bus.frame_valid, 1'b1);
    beat("f1_after", 0, 0, 8'h00);
    chk("f1_fv_pulse", bus.frame_valid, 1'b0);

    beat("gap_s0", 1, 1, 8'h55); idle("gap_i0");
    beat("gap_s1", 1, 0, 8'h66); idle("gap_i1");
    beat("gap_s2", 1, 0, 8'h77); idle("gap_i2");
    beat("gap_s3", 1, 0, 8'h88);
    chk("gap_data", bus.ch_data, 32'h88776655);
    chk("gap_fv", bus.frame_valid, 1'b1);

    beat("early_s0", 1, 1, 8'h01);
    beat("early_s1", 1, 0, 8'h02);
    beat("early_sync", 1, 1, 8'h0A);
    chk("early_err", bus.sync_err, 1'b1);
    chk("early_locked", bus.locked, 1'b1);
    beat("early_s1b", 1, 0, 8'h0B);
    beat("early_s2b", 1, 0, 8'h0C);
    beat("early_s3b", 1, 0, 8'h0D);
    chk("early_fv", bus.frame_valid, 1'b1);
    chk("early_data", bus.ch_data, 32'h0D0C0B0A);

    beat("miss_sync", 1, 0, 8'hEE);
    chk("miss_err", bus.sync_err, 1'b1);
    chk("miss_unlocked", bus.locked, 1'b0);

    beat("rst_s0", 1, 1, 8'h5A);
    beat("rst_s1", 1, 0, 8'hA5);
    @(negedge clk);
    bus.din_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      logic v, f;
      v = ($urandom_range(0, 3) != 0);
      if (!m_lock || m_frame.size() == 0) f = ($urandom_range(0, 7) != 0);
      else                                f = ($urandom_range(0, 11) == 0);
      beat("rand", v, f, 8'($urandom));
      chk("rand_excl", bus.sync_err & bus.frame_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
